wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive lost cycles after which the FIFO head is forced onto the write port (legal range 2..15).
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 pipe_wb_valid  in  1  main pipeline writeback request this cycle.
REQ-005 pipe_wb_reg  in  5  destination register of the pipeline request.
REQ-006 pipe_wb_data  in  32  write data of the pipeline request.
REQ-007 lu_valid  in  1  long-latency unit result valid.
REQ-008 lu_reg  in  5  destination register of the long-latency result.
REQ-009 lu_data  in  32  long-latency result data.
REQ-010 lu_ready  out  1  FIFO can accept a result; combinational, equals (fifo_count < 2).
REQ-011 rf_we  out  1  register-file write enable, registered.
REQ-012 rf_waddr  out  5  register-file write address, registered.
REQ-013 rf_wdata  out  32  register-file write data, registered.
REQ-014 pipe_stall  out  1  registered; the pipeline must hold its writeback inputs while this is high.
REQ-015 fifo_count  out  2  FIFO occupancy, range 0..2.

Function
REQ-016 The block SHALL share one register-file write port between the pipeline and a 2-entry FIFO of long-latency results.
REQ-017 Push: when lu_valid && lu_ready, {lu_reg, lu_data} SHALL be enqueued at the tail; a push into an empty FIFO SHALL NOT be poppable in the same cycle.
REQ-018 Grant priority each cycle:
- (a) pipe_stall=1: grant the FIFO head and ignore pipe_wb_valid.
- (b) else pipe_wb_valid=1 and pipe_wb_reg!=0: grant the pipeline.
- (c) else FIFO non-empty: grant the FIFO head.
- (d) else: no grant.
REQ-019 A granted request SHALL appear on rf_we/rf_waddr/rf_wdata exactly one cycle later; in a cycle with no write, rf_we SHALL be 0 and rf_waddr/rf_wdata SHALL hold their previous values.
REQ-020 A pipeline request to register 0 SHALL NOT write and SHALL leave the port free for rule (c) in the same cycle.
REQ-021 A FIFO head granted under (a) or (c) SHALL be popped; if its reg is 0 or it is killed, it SHALL be popped with rf_we=0 next cycle.
REQ-022 WAW kill: on a pipeline grant to register R, every FIFO entry with reg R SHALL be marked killed in that same cycle. This includes an entry pushed in that same cycle.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged; with count=2, lu_ready=0, so no push occurs in that cycle.
REQ-024 Starvation counter (4 bits):
- increments in each cycle where the FIFO is non-empty at cycle start and the pipeline is granted;
- clears on any FIFO grant or when the FIFO is empty.
REQ-025 pipe_stall SHALL be set for exactly one cycle on the edge where the counter reaches STARVE_LIMIT. The counter SHALL clear in that stall cycle.
REQ-026 pipe_stall SHALL NOT be asserted on two consecutive cycles.
REQ-027 Entries SHALL pop in FIFO order. Tail pointer wrap-around at depth 2 SHALL NOT corrupt order.

Reset
REQ-028 While RESET=0, all of the following SHALL hold, independent of CLK:
- rf_we=0, rf_waddr=0, rf_wdata=0;
- pipe_stall=0, fifo_count=0, starvation counter=0;
- all kill flags cleared.
REQ-029 Reset mid-operation SHALL discard all FIFO contents without any register-file write. After release, lu_ready=1.

Verification
REQ-030 Single pipeline write: pipe_wb_valid=1, reg=5, data=0xDEADBEEF at cycle N -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-031 Idle pipeline:
- stimulus: lu_valid=1, reg=7, data=0x11 at N; pipe idle.
- response: push at N, grant at N+1, rf_we=1 with waddr=7 and wdata=0x11 at N+2.
REQ-032 Starvation:
- stimulus: FIFO holds reg 3; pipeline writes reg 4 for 4 consecutive cycles.
- response: pipe_stall=1 for one cycle; reg 3 is written the cycle after that; pipe_stall returns to 0.
REQ-033 WAW kill:
- stimulus: FIFO holds {reg 9, 0xAA}; pipeline grants reg 9 with 0xBB.
- response: rf writes 9/0xBB; the later pop of the reg 9 entry gives rf_we=0; fifo_count decrements.
REQ-034 Full FIFO:
- stimulus: two pushes with pipeline busy.
- response: fifo_count=2, lu_ready=0, a third lu_valid is not accepted.
- after one pop: lu_ready=1.
REQ-035 Reset mid-operation:
- stimulus: RESET=0 asynchronously while fifo_count=2 and pipe_stall=1.
- response: all outputs 0 immediately; after release, no write occurs until a new request.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Shares one register-file write port between the main pipeline writeback
//   and a 2-entry FIFO of long-latency unit results. The pipeline normally
//   wins. A starvation counter forces a one-cycle pipeline stall so the FIFO
//   head can drain. A pipeline write to register R kills every queued result
//   for R (WAW), so a stale long-latency value never overwrites a newer one.
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   pipe_wb_valid/reg/data     : pipeline writeback request
//   lu_valid/reg/data          : long-latency result offered to the FIFO
//   lu_ready                   : FIFO can accept (fifo_count < 2), combinational
//   rf_we/rf_waddr/rf_wdata    : registered register-file write port
//   pipe_stall                 : registered; pipeline holds its request while high
//   fifo_count                 : FIFO occupancy 0..2
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_wb_valid,
    input  logic [4:0]  pipe_wb_reg,
    input  logic [31:0] pipe_wb_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_reg,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        pipe_stall,
    output logic [1:0]  fifo_count
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    // FIFO storage and control state
    logic [4:0]  ent_reg_r  [2];
    logic [31:0] ent_data_r [2];
    logic [1:0]  kill_r;
    logic        head_r;
    logic [1:0]  count_r;
    logic [3:0]  starve_r;
    logic        pipe_stall_r;
    logic        rf_we_r;
    logic [4:0]  rf_waddr_r;
    logic [31:0] rf_wdata_r;

    // Next-state / decode signals
    logic        lu_ready_s;
    logic        fifo_nonempty_s;
    logic        push_s;
    logic        tail_s;
    logic        grant_pipe_s;
    logic        grant_fifo_s;
    logic        head_write_s;
    logic [1:0]  count_nxt_s;
    logic [1:0]  kill_nxt_s;
    logic [3:0]  starve_nxt_s;
    logic        stall_nxt_s;

    assign lu_ready   = lu_ready_s;
    assign rf_we      = rf_we_r;
    assign rf_waddr   = rf_waddr_r;
    assign rf_wdata   = rf_wdata_r;
    assign pipe_stall = pipe_stall_r;
    assign fifo_count = count_r;

    // Push acceptance and tail slot; the tail is only used while count <= 1,
    // so head + count reduces to head XOR count[0].
    always_comb begin
        lu_ready_s      = (count_r < 2'd2);
        fifo_nonempty_s = (count_r != 2'd0);
        push_s          = lu_valid && lu_ready_s;
        tail_s          = head_r ^ count_r[0];
    end

    // Grant selection. Occupancy is taken at cycle start, so an entry pushed
    // this cycle cannot be granted until the next one.
    always_comb begin
        grant_pipe_s = 1'b0;
        grant_fifo_s = 1'b0;
        if (pipe_stall_r) begin
            grant_fifo_s = fifo_nonempty_s;
        end else if (pipe_wb_valid && (pipe_wb_reg != 5'd0)) begin
            grant_pipe_s = 1'b1;
        end else if (fifo_nonempty_s) begin
            grant_fifo_s = 1'b1;
        end else begin
            grant_fifo_s = 1'b0;
        end
        // A popped head only writes when it is live and not aimed at r0
        head_write_s = grant_fifo_s && !kill_r[head_r] && (ent_reg_r[head_r] != 5'd0);
    end

    // Occupancy update; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, grant_fifo_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // WAW kill flags, including a result pushed in the same cycle as the
    // pipeline grant. A freshly pushed slot otherwise starts live.
    always_comb begin
        kill_nxt_s = kill_r;
        for (int i = 0; i < 2; i++) begin
            if (push_s && (tail_s == i[0])) begin
                kill_nxt_s[i] = grant_pipe_s && (lu_reg == pipe_wb_reg);
            end else begin
                kill_nxt_s[i] = kill_r[i] | (grant_pipe_s && (ent_reg_r[i] == pipe_wb_reg));
            end
        end
    end

    // Starvation tracking; the stall fires on the edge where the count hits
    // the limit and the following FIFO grant clears the count, so two stall
    // cycles can never be adjacent.
    always_comb begin
        if (!fifo_nonempty_s) begin
            starve_nxt_s = 4'd0;
        end else if (grant_fifo_s) begin
            starve_nxt_s = 4'd0;
        end else if (grant_pipe_s) begin
            starve_nxt_s = starve_r + 4'd1;
        end else begin
            starve_nxt_s = starve_r;
        end
        stall_nxt_s = !pipe_stall_r && (starve_nxt_s == LIMIT_C);
    end

    // FIFO, counter and stall state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_reg_r[0]  <= 5'd0;
            ent_reg_r[1]  <= 5'd0;
            ent_data_r[0] <= 32'd0;
            ent_data_r[1] <= 32'd0;
            kill_r        <= 2'b00;
            head_r        <= 1'b0;
            count_r       <= 2'd0;
            starve_r      <= 4'd0;
            pipe_stall_r  <= 1'b0;
        end else begin
            if (push_s) begin
                ent_reg_r[tail_s]  <= lu_reg;
                ent_data_r[tail_s] <= lu_data;
            end
            if (grant_fifo_s) begin
                head_r <= ~head_r;
            end
            kill_r       <= kill_nxt_s;
            count_r      <= count_nxt_s;
            starve_r     <= starve_nxt_s;
            pipe_stall_r <= stall_nxt_s;
        end
    end

    // Registered write port; address and data hold when nothing is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'd0;
            rf_wdata_r <= 32'd0;
        end else if (grant_pipe_s) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= pipe_wb_reg;
            rf_wdata_r <= pipe_wb_data;
        end else if (head_write_s) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= ent_reg_r[head_r];
            rf_wdata_r <= ent_data_r[head_r];
        end else begin
            rf_we_r    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Directed bench for wb_port_arbiter: a table of per-cycle input/expected
//   output records, followed by a hand-written mid-operation reset sequence.
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_reg;
    logic [31:0] pipe_wb_data;
    logic        lu_valid;
    logic [4:0]  lu_reg;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic [1:0]  fifo_count;

    int checks_total;
    int checks_passed;

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_wb_valid(pipe_wb_valid),
        .pipe_wb_reg  (pipe_wb_reg),
        .pipe_wb_data (pipe_wb_data),
        .lu_valid     (lu_valid),
        .lu_reg       (lu_reg),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pipe_stall   (pipe_stall),
        .fifo_count   (fifo_count)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        pv;
        logic [4:0]  preg;
        logic [31:0] pdata;
        logic        lv;
        logic [4:0]  lreg;
        logic [31:0] ldata;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        stall;
        logic [1:0]  cnt;
        logic        rdy;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic pv, input logic [4:0] preg, input logic [31:0] pdata,
                                input logic lv, input logic [4:0] lreg, input logic [31:0] ldata,
                                input logic we, input logic [4:0] addr, input logic [31:0] data,
                                input logic stall, input logic [1:0] cnt, input logic rdy);
        vec_t v;
        v.pv = pv; v.preg = preg; v.pdata = pdata;
        v.lv = lv; v.lreg = lreg; v.ldata = ldata;
        v.we = we; v.addr = addr; v.data = data;
        v.stall = stall; v.cnt = cnt; v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic chk_all(input string tag, input logic we, input logic [4:0] addr,
                           input logic [31:0] data, input logic stall, input logic [1:0] cnt,
                           input logic rdy);
        chk({tag, ".rf_we"},      {31'd0, rf_we},      {31'd0, we});
        chk({tag, ".rf_waddr"},   {27'd0, rf_waddr},   {27'd0, addr});
        chk({tag, ".rf_wdata"},   rf_wdata,            data);
        chk({tag, ".pipe_stall"}, {31'd0, pipe_stall}, {31'd0, stall});
        chk({tag, ".fifo_count"}, {30'd0, fifo_count}, {30'd0, cnt});
        chk({tag, ".lu_ready"},   {31'd0, lu_ready},   {31'd0, rdy});
    endtask

    task automatic drive(input logic pv, input logic [4:0] preg, input logic [31:0] pdata,
                         input logic lv, input logic [4:0] lreg, input logic [31:0] ldata);
        pipe_wb_valid = pv;
        pipe_wb_reg   = preg;
        pipe_wb_data  = pdata;
        lu_valid      = lv;
        lu_reg        = lreg;
        lu_data       = ldata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        //           pv    preg   pdata          lv    lreg   ldata         we    addr   data           stall cnt    rdy
        vecs[0]  = mk(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,       1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 2'd0, 1'b1);
        vecs[1]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h11,      1'b0, 5'd5,  32'hDEADBEEF, 1'b0, 2'd1, 1'b1);
        vecs[2]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b1, 5'd7,  32'h11,       1'b0, 2'd0, 1'b1);
        vecs[3]  = mk(1'b1, 5'd0,  32'h55,       1'b1, 5'd9,  32'hAA,      1'b0, 5'd7,  32'h11,       1'b0, 2'd1, 1'b1);
        vecs[4]  = mk(1'b1, 5'd9,  32'hBB,       1'b0, 5'd0,  32'h0,       1'b1, 5'd9,  32'hBB,       1'b0, 2'd1, 1'b1);
        vecs[5]  = mk(1'b1, 5'd0,  32'h66,       1'b0, 5'd0,  32'h0,       1'b0, 5'd9,  32'hBB,       1'b0, 2'd0, 1'b1);
        vecs[6]  = mk(1'b1, 5'd1,  32'h101,      1'b1, 5'd2,  32'h202,     1'b1, 5'd1,  32'h101,      1'b0, 2'd1, 1'b1);
        vecs[7]  = mk(1'b1, 5'd1,  32'h102,      1'b1, 5'd6,  32'h606,     1'b1, 5'd1,  32'h102,      1'b0, 2'd2, 1'b0);
        vecs[8]  = mk(1'b1, 5'd1,  32'h103,      1'b1, 5'd8,  32'h808,     1'b1, 5'd1,  32'h103,      1'b0, 2'd2, 1'b0);
        vecs[9]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  32'h808,     1'b1, 5'd2,  32'h202,      1'b0, 2'd1, 1'b1);
        vecs[10] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b1, 5'd6,  32'h606,      1'b0, 2'd0, 1'b1);
        vecs[11] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hC0,      1'b0, 5'd6,  32'h606,      1'b0, 2'd1, 1'b1);
        vecs[12] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd13, 32'hD0,      1'b1, 5'd12, 32'hC0,       1'b0, 2'd1, 1'b1);
        vecs[13] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd14, 32'hE0,      1'b1, 5'd13, 32'hD0,       1'b0, 2'd1, 1'b1);
        vecs[14] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b1, 5'd14, 32'hE0,       1'b0, 2'd0, 1'b1);
        vecs[15] = mk(1'b1, 5'd4,  32'h40,       1'b1, 5'd3,  32'h33,      1'b1, 5'd4,  32'h40,       1'b0, 2'd1, 1'b1);
        vecs[16] = mk(1'b1, 5'd4,  32'h41,       1'b0, 5'd0,  32'h0,       1'b1, 5'd4,  32'h41,       1'b0, 2'd1, 1'b1);
        vecs[17] = mk(1'b1, 5'd4,  32'h42,       1'b0, 5'd0,  32'h0,       1'b1, 5'd4,  32'h42,       1'b0, 2'd1, 1'b1);
        vecs[18] = mk(1'b1, 5'd4,  32'h43,       1'b0, 5'd0,  32'h0,       1'b1, 5'd4,  32'h43,       1'b0, 2'd1, 1'b1);
        vecs[19] = mk(1'b1, 5'd4,  32'h44,       1'b0, 5'd0,  32'h0,       1'b1, 5'd4,  32'h44,       1'b1, 2'd1, 1'b1);
        vecs[20] = mk(1'b1, 5'd4,  32'h45,       1'b0, 5'd0,  32'h0,       1'b1, 5'd3,  32'h33,       1'b0, 2'd0, 1'b1);
        vecs[21] = mk(1'b1, 5'd4,  32'h45,       1'b0, 5'd0,  32'h0,       1'b1, 5'd4,  32'h45,       1'b0, 2'd0, 1'b1);
        vecs[22] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 5'd4,  32'h45,       1'b0, 2'd0, 1'b1);
        vecs[23] = mk(1'b1, 5'd9,  32'hC9,       1'b1, 5'd9,  32'h99,      1'b1, 5'd9,  32'hC9,       1'b0, 2'd1, 1'b1);
        vecs[24] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 5'd9,  32'hC9,       1'b0, 2'd0, 1'b1);

        // Reset state, checked before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk_all("reset", 1'b0, 5'd0, 32'd0, 1'b0, 2'd0, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("post_reset", 1'b0, 5'd0, 32'd0, 1'b0, 2'd0, 1'b1);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].pv, vecs[i].preg, vecs[i].pdata, vecs[i].lv, vecs[i].lreg, vecs[i].ldata);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
                    vecs[i].stall, vecs[i].cnt, vecs[i].rdy);
        end

        // Mid-operation reset: fill the FIFO and starve it until the stall fires
        drive(1'b1, 5'd4, 32'h50, 1'b1, 5'd3, 32'h31);
        tick();
        drive(1'b1, 5'd4, 32'h51, 1'b1, 5'd5, 32'h51);
        tick();
        drive(1'b1, 5'd4, 32'h52, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b1, 5'd4, 32'h53, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b1, 5'd4, 32'h54, 1'b0, 5'd0, 32'h0);
        tick();
        chk_all("pre_rst", 1'b1, 5'd4, 32'h54, 1'b1, 2'd2, 1'b0);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 5'd0, 32'd0, 1'b0, 2'd0, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all($sformatf("idle_after_rst%0d", k), 1'b0, 5'd0, 32'd0, 1'b0, 2'd0, 1'b1);
        end
        drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
        tick();
        chk_all("new_req", 1'b1, 5'd7, 32'h77, 1'b0, 2'd0, 1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
